// File: rtl/and_share_arb.sv
// Round-robin arbiter sharing one registered AND datapath among NUM_REQ requesters.
// Results return on a valid/ready channel tagged with the winning requester index.
module and_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [WIDTH-1:0]         o_rsp_c,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic [CNT_W-1:0]         o_op_count,
  output logic                     o_busy
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [WIDTH-1:0]  r_rsp_c;
  logic [ID_W-1:0]   r_rsp_id;
  logic [CNT_W-1:0]  r_op_count;

  logic              w_can_accept;
  logic              w_found;
  logic [ID_W-1:0]   w_win;
  logic [ID_W:0]     w_idx;
  logic              w_accept;
  logic              w_consume;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic [WIDTH-1:0]  w_and;

  assign w_can_accept = (r_state == ST_EMPTY) | i_rsp_ready;
  assign w_accept     = w_can_accept & w_found;
  assign w_consume    = (r_state == ST_FULL) & i_rsp_ready;

  // Search requesters from the round-robin pointer upward, wrapping at NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
        w_idx = w_idx - (ID_W+1)'(NUM_REQ);
      end else begin
        w_idx = w_idx;
      end
      if (!w_found && i_req_valid[w_idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[ID_W-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  // One-hot grant to the winner only when the output slot can take a result.
  always_comb begin
    o_req_ready = '0;
    if (w_accept) begin
      o_req_ready[w_win] = 1'b1;
    end else begin
      o_req_ready = '0;
    end
  end

  // Pointer advances past the winner, wrapping to requester 0.
  always_comb begin
    w_ptr_nxt = '0;
    if (w_win == ID_W'(NUM_REQ-1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_win + ID_W'(1);
    end
  end

  assign w_and = i_req_a[w_win*WIDTH +: WIDTH] & i_req_b[w_win*WIDTH +: WIDTH];

  // Output slot state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output slot next state: a consume with a simultaneous accept stays FULL.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (i_rsp_ready && !w_accept) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Result, tag and pointer load on accept; otherwise held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_c  <= '0;
      r_rsp_id <= '0;
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rsp_c  <= w_and;
      r_rsp_id <= w_win;
      r_rr_ptr <= w_ptr_nxt;
    end else begin
      r_rsp_c  <= r_rsp_c;
      r_rsp_id <= r_rsp_id;
      r_rr_ptr <= r_rr_ptr;
    end
  end

  // Count consumed results, wrapping naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op_count <= '0;
    end else if (w_consume) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end else begin
      r_op_count <= r_op_count;
    end
  end

  assign o_rsp_valid = (r_state == ST_FULL);
  assign o_rsp_c     = r_rsp_c;
  assign o_rsp_id    = r_rsp_id;
  assign o_op_count  = r_op_count;
  assign o_busy      = (r_state == ST_FULL) | (|i_req_valid);

endmodule

// File: doc/and_share_arb.md
Name: and_share_arb

Overview:
- Shares one registered bitwise-AND datapath (c = a & b) among NUM_REQ requesters using round-robin arbitration.
- Each requester presents an operand pair over a valid/ready handshake.
- The winning pair is ANDed into a single-entry output register and returned on a valid/ready response channel, tagged with the requester index.
- Sits between the lib_tb_a stimulus agents and any consumer, so several agents can exercise the AND function concurrently.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH, 8, operand/result width in bits.
- ID_W, 2, width of requester index; must satisfy 2**ID_W >= NUM_REQ.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant/accept; one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand b; same packing as req_a.
- rsp_valid  out  1  result register holds a result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_c  out  WIDTH  a & b of the granted request.
- rsp_id  out  ID_W  index of the requester that produced rsp_c.
- op_count  out  CNT_W  number of results consumed (rsp handshakes).
- busy  out  1  high when rsp_valid is high or any req_valid bit is high.

Behaviour:
- **Reset.** rst_n low asynchronously forces rsp_valid=0, rsp_c=0, rsp_id=0, op_count=0, and the round-robin pointer rr_ptr=0. req_ready is combinational and therefore 0 while rsp_valid=0 and no req_valid is asserted.
- **Output state machine** has two states, derived from rsp_valid:
  - EMPTY (rsp_valid=0) -> FULL on accept.
  - FULL -> FULL on (rsp_ready & accept).
  - FULL -> EMPTY on (rsp_ready & no accept).
  - FULL holds when rsp_ready=0.
- **can_accept** = !rsp_valid | rsp_ready. Back-to-back throughput is 1 op/cycle.
- **Arbitration** is combinational. Search req_valid starting at index rr_ptr, ascending, wrapping modulo NUM_REQ. The first set bit is the winner w.
  - req_ready[w] = can_accept & (|req_valid). All other req_ready bits are 0.
  - req_ready must never assert for a requester whose req_valid is 0.
- **On an accept clock edge:**
  - rsp_c <= req_a[w] & req_b[w]
  - rsp_id <= w
  - rsp_valid <= 1
  - rr_ptr <= (w+1) mod NUM_REQ
- **Latency:** the result is visible on rsp_c exactly 1 cycle after the request handshake edge.
- **rr_ptr** changes only on accept. An idle cycle or a stalled cycle leaves it unchanged.
- **Stall:** while rsp_valid=1 and rsp_ready=0, rsp_c and rsp_id are held stable and all req_ready bits are 0.
- **Simultaneous consume and accept** in the same cycle: the new result replaces the old one. rsp_valid stays 1 and no bubble is inserted.
- **Requester rule:** once req_valid[i] is raised, it and the operands for i stay stable until req_ready[i]. The arbiter does not lock a winner; a requester may lose to a higher-priority one while waiting.
- **Fairness:** with all requesters continuously valid and rsp_ready=1, grants rotate 0,1,2,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 accepts.
- **op_count** increments by 1 on each rsp_valid & rsp_ready edge and wraps from 2**CNT_W-1 to 0.
- **Mid-operation reset:** a held result is discarded, with no rsp handshake and no count. After release, arbitration restarts at requester 0.
- **Width rule:** rsp_c is exactly WIDTH bits with no extension. Unused rsp_id codes (>= NUM_REQ) are never produced.

Test Plan:
- **Single requester:** req 2 sends a=0xF0, b=0x3C with rsp_ready=1 -> req_ready[2]=1 that cycle; next cycle rsp_valid=1, rsp_c=0x30, rsp_id=2; op_count=1 after the consume edge.
- **All four continuously valid,** rsp_ready=1, 8 cycles -> grant order 0,1,2,3,0,1,2,3; one result per cycle; op_count=8.
- **Back-pressure:** result 0xA5&0x0F pending and rsp_ready held 0 for 5 cycles -> rsp_c=0x05 stable, all req_ready=0. On rsp_ready=1, the pending request is accepted in the same cycle, with no bubble.
- **Pointer hold:** grant req 1, idle 3 cycles, then req 0 and req 3 both valid -> req 3 is granted first (rr_ptr=2), then req 0.
- **Reset mid-stall:** rsp_valid=1, rsp_ready=0, op_count=5, then assert rst_n=0 asynchronously -> rsp_valid=0, op_count=0 immediately. After release, requests 1 and 3 both valid -> req 1 is granted first.
- **Randomised:** 50 random a/b per requester, random rsp_ready -> every rsp_c equals a&b of the matching rsp_id in per-requester order; op_count=200 at end.
